// File: rtl/uart_frame_sequencer_pkg.sv
// Shared definitions for the UART frame sequencer: state encoding,
// default error fill byte and the saturating counter helper.
package uart_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_COLLECT     = 3'd0,
    ST_DISPATCH    = 3'd1,
    ST_WAIT_RESULT = 3'd2,
    ST_SEND        = 3'd3,
    ST_WAIT_TX     = 3'd4
  } seq_state_t;

  localparam logic [7:0] DEFAULT_ERR_BYTE = 8'hEE;

  // 8-bit increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_frame_sequencer_frame_assembler.sv
// Packs received characters into a frame, little-end first, and discards
// a partial frame when the line goes quiet for too long.
module uart_frame_sequencer_frame_assembler
  import uart_frame_sequencer_pkg::*;
#(
  parameter int DBITS       = 8,
  parameter int FRAME_BYTES = 8,
  parameter int GAP_CYCLES  = 1_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         byte_valid,
  input  logic [DBITS-1:0]             byte_in,
  output logic [FRAME_BYTES*DBITS-1:0] frame,
  output logic                         frame_done,
  output logic [7:0]                   resync_count
);

  localparam int IW = $clog2(FRAME_BYTES);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [IW-1:0] idx;
  logic [GW-1:0] gap;
  logic          take;

  // bytes are only taken while the sequencer is collecting
  assign take = byte_valid & en;

  // index, byte placement, gap timer and resync counter
  always_ff @(posedge clk) begin
    if (reset) begin
      idx          <= '0;
      gap          <= '0;
      frame        <= '0;
      frame_done   <= 1'b0;
      resync_count <= '0;
    end else begin
      frame_done <= 1'b0;
      for (int k = 0; k < FRAME_BYTES; k++)
        if (take && idx == IW'(k)) frame[k*DBITS +: DBITS] <= byte_in;
      if (take) begin
        // an arriving byte always beats an expiring gap timer
        gap <= '0;
        if (idx == LAST_IDX) begin
          idx        <= '0;
          frame_done <= 1'b1;
        end else begin
          idx <= idx + IW'(1);
        end
      end else if (idx != '0) begin
        if (gap == GAP_LAST) begin
          idx          <= '0;
          gap          <= '0;
          resync_count <= sat_inc8(resync_count);
        end else begin
          gap <= gap + GW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/uart_frame_sequencer.sv
// Sequences UART RX bytes -> coprocessor frame -> result -> UART TX,
// with a result timeout and TX backpressure handling.
module uart_frame_sequencer
  import uart_frame_sequencer_pkg::*;
#(
  parameter int               DBITS          = 8,
  parameter int               FRAME_BYTES    = 8,
  parameter int               GAP_CYCLES     = 1_000_000,
  parameter int               TIMEOUT_CYCLES = 4_000_000,
  parameter logic [DBITS-1:0] ERR_BYTE       = DBITS'(DEFAULT_ERR_BYTE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DBITS-1:0]             rx_byte,
  input  logic                         rx_byte_valid,
  output logic [FRAME_BYTES*DBITS-1:0] cp_din,
  output logic                         cp_din_valid,
  input  logic [FRAME_BYTES*DBITS-1:0] cp_dout,
  input  logic                         cp_dout_valid,
  output logic [FRAME_BYTES*DBITS-1:0] tx_frame,
  output logic                         tx_send,
  input  logic                         tx_busy,
  output logic [2:0]                   state,
  output logic                         err_timeout,
  output logic [7:0]                   overrun_count,
  output logic [7:0]                   resync_count
);

  localparam int FW = FRAME_BYTES * DBITS;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  seq_state_t    st, st_nx;
  logic [TW-1:0] cp_timer;
  logic [1:0]    wtx_cnt;
  logic          timeout_hit;
  logic          frame_done;
  logic [FW-1:0] asm_frame;

  uart_frame_sequencer_frame_assembler #(
    .DBITS      (DBITS),
    .FRAME_BYTES(FRAME_BYTES),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_asm (
    .clk         (clk),
    .reset       (reset),
    .en          (st == ST_COLLECT),
    .byte_valid  (rx_byte_valid),
    .byte_in     (rx_byte),
    .frame       (asm_frame),
    .frame_done  (frame_done),
    .resync_count(resync_count)
  );

  assign state       = st;
  assign timeout_hit = (cp_timer == TW'(TIMEOUT_CYCLES - 1));

  // state register
  always_ff @(posedge clk) begin
    if (reset) st <= ST_COLLECT;
    else       st <= st_nx;
  end

  // next-state logic
  always_comb begin
    st_nx = st;
    unique case (st)
      ST_COLLECT:     if (frame_done) st_nx = ST_DISPATCH;
      ST_DISPATCH:    st_nx = ST_WAIT_RESULT;
      ST_WAIT_RESULT: if (cp_dout_valid || timeout_hit) st_nx = ST_SEND;
      ST_SEND:        if (!tx_busy) st_nx = ST_WAIT_TX;
      // hold two cycles so a late-rising tx_busy is still seen
      ST_WAIT_TX:     if (wtx_cnt == 2'd2 && !tx_busy) st_nx = ST_COLLECT;
      default:        st_nx = ST_COLLECT;
    endcase
  end

  // timers: result timeout counts only in WAIT_RESULT, WAIT_TX dwell counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cp_timer <= '0;
      wtx_cnt  <= '0;
    end else begin
      cp_timer <= (st == ST_WAIT_RESULT) ? cp_timer + TW'(1) : '0;
      if (st != ST_WAIT_TX)    wtx_cnt <= '0;
      else if (wtx_cnt != 2'd2) wtx_cnt <= wtx_cnt + 2'd1;
    end
  end

  // frame issue, result capture and TX strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      cp_din       <= '0;
      cp_din_valid <= 1'b0;
      tx_frame     <= '0;
      tx_send      <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      cp_din_valid <= 1'b0;
      tx_send      <= 1'b0;
      // cp_din is captured once per frame and held until the next one
      if (st == ST_COLLECT && frame_done) begin
        cp_din       <= asm_frame;
        cp_din_valid <= 1'b1;
      end
      if (st == ST_WAIT_RESULT) begin
        if (cp_dout_valid) begin
          tx_frame <= cp_dout;
        end else if (timeout_hit) begin
          tx_frame    <= {FRAME_BYTES{ERR_BYTE}};
          err_timeout <= 1'b1;
        end
      end
      if (st == ST_SEND && !tx_busy) tx_send <= 1'b1;
    end
  end

  // bytes arriving outside COLLECT are dropped and counted
  always_ff @(posedge clk) begin
    if (reset)                                overrun_count <= '0;
    else if (rx_byte_valid && st != ST_COLLECT) overrun_count <= sat_inc8(overrun_count);
  end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Bench for uart_frame_sequencer: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// behavioural model of the sequencer.
module tb_uart_frame_sequencer;

  localparam int FB  = 8;
  localparam int GAP = 100;
  localparam int TO  = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_byte = '0;
  logic          rx_byte_valid = 1'b0;
  logic [63:0]   cp_din;
  logic          cp_din_valid;
  logic [63:0]   cp_dout = '0;
  logic          cp_dout_valid = 1'b0;
  logic [63:0]   tx_frame;
  logic          tx_send;
  logic          tx_busy = 1'b0;
  logic [2:0]    state;
  logic          err_timeout;
  logic [7:0]    overrun_count;
  logic [7:0]    resync_count;

  uart_frame_sequencer #(
    .DBITS(8), .FRAME_BYTES(FB), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .ERR_BYTE(8'hEE)
  ) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .cp_din(cp_din), .cp_din_valid(cp_din_valid), .cp_dout(cp_dout),
    .cp_dout_valid(cp_dout_valid), .tx_frame(tx_frame), .tx_send(tx_send),
    .tx_busy(tx_busy), .state(state), .err_timeout(err_timeout),
    .overrun_count(overrun_count), .resync_count(resync_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cnt = 0;
  int cpv_cnt = 0, send_cnt = 0;

  // behavioural model: what the outputs must be after the coming edge
  int          m_state = 0;
  logic [7:0]  m_q[$];
  int          m_last = 0;
  bit          m_pend = 0;
  logic [63:0] m_pend_frame = '0;
  logic [63:0] m_cp_din = '0, m_tx_frame = '0;
  bit          m_cpv = 0, m_send = 0, m_err = 0;
  int          m_ovr = 0, m_rsy = 0, m_wait = 0, m_wtx = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h expected %h", nm, cnt, act, exp);
  endtask

  task automatic model_step();
    bit done_now;
    done_now = 0;
    if (reset) begin
      m_state = 0; m_q.delete(); m_pend = 0; m_cp_din = '0; m_tx_frame = '0;
      m_cpv = 0; m_send = 0; m_err = 0; m_ovr = 0; m_rsy = 0; m_wait = 0; m_wtx = 0;
      return;
    end
    m_cpv = 0; m_send = 0;
    // byte intake: only in COLLECT, otherwise an overrun
    if (rx_byte_valid && m_state != 0) m_ovr = (m_ovr == 255) ? 255 : m_ovr + 1;
    if (rx_byte_valid && m_state == 0) begin
      m_q.push_back(rx_byte);
      m_last = cnt;
      if (m_q.size() == FB) begin
        for (int k = 0; k < FB; k++) m_pend_frame[k*8 +: 8] = m_q[k];
        m_q.delete();
        done_now = 1;
      end
    end else if (m_q.size() > 0 && cnt - m_last == GAP) begin
      m_q.delete();
      m_rsy = (m_rsy == 255) ? 255 : m_rsy + 1;
    end
    case (m_state)
      0: if (m_pend) begin m_cp_din = m_pend_frame; m_cpv = 1; m_state = 1; end
      1: begin m_state = 2; m_wait = 0; end
      2: begin
        m_wait++;
        if (cp_dout_valid) begin m_tx_frame = cp_dout; m_state = 3; end
        else if (m_wait == TO) begin m_tx_frame = {8{8'hEE}}; m_err = 1; m_state = 3; end
      end
      3: if (!tx_busy) begin m_send = 1; m_state = 4; m_wtx = 0; end
      4: begin m_wtx++; if (m_wtx >= 3 && !tx_busy) m_state = 0; end
      default: m_state = 0;
    endcase
    m_pend = done_now;
  endtask

  // one clock: advance model, take the edge, compare away from it
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    cnt++;
    if (cp_din_valid) cpv_cnt++;
    if (tx_send) send_cnt++;
    chk("state", 64'(state), 64'(m_state));
    chk("cp_din", cp_din, m_cp_din);
    chk("cp_din_valid", 64'(cp_din_valid), 64'(m_cpv));
    chk("tx_frame", tx_frame, m_tx_frame);
    chk("tx_send", 64'(tx_send), 64'(m_send));
    chk("err_timeout", 64'(err_timeout), 64'(m_err));
    chk("overrun_count", 64'(overrun_count), 64'(m_ovr));
    chk("resync_count", 64'(resync_count), 64'(m_rsy));
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b; rx_byte_valid = 1'b1;
    cyc();
    rx_byte_valid = 1'b0;
  endtask

  task automatic frame_in(input logic [7:0] base);
    for (int k = 0; k < FB; k++) send_byte(base + 8'(k));
  endtask

  task automatic do_reset();
    reset = 1'b1; rx_byte_valid = 0; cp_dout_valid = 0; tx_busy = 0;
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic echo_at(input int n, input logic [63:0] d);
    repeat (n) cyc();
    cp_dout = d; cp_dout_valid = 1'b1;
    cyc();
    cp_dout_valid = 1'b0;
  endtask

  initial begin
    int s0, c0, resp_at, quiet;

    // reset state
    do_reset();
    chk("rst_state", 64'(state), 0);
    chk("rst_cp_din", cp_din, 0);
    chk("rst_tx_frame", tx_frame, 0);
    chk("rst_strobes", 64'({cp_din_valid, tx_send}), 0);
    chk("rst_err", 64'(err_timeout), 0);
    chk("rst_counts", 64'({overrun_count, resync_count}), 0);

    // normal frame, echo 10 cycles after dispatch
    c0 = cpv_cnt; s0 = send_cnt;
    frame_in(8'h01);
    cyc();
    chk("norm_cpv_lat", 64'(cp_din_valid), 1);
    chk("norm_cp_din", cp_din, 64'h0807060504030201);
    echo_at(10, 64'h1122334455667788);
    cyc();
    chk("norm_send_lat", 64'(tx_send), 1);
    chk("norm_tx_frame", tx_frame, 64'h1122334455667788);
    repeat (3) cyc();
    chk("norm_back", 64'(state), 0);
    chk("norm_cpv_once", 64'(cpv_cnt - c0), 1);
    chk("norm_send_once", 64'(send_cnt - s0), 1);

    // gap resync, then timeout with no result
    do_reset();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    repeat (150) cyc();
    chk("gap_resync", 64'(resync_count), 1);
    frame_in(8'hAA);
    cyc();
    chk("gap_cpv", 64'(cp_din_valid), 1);
    chk("gap_cp_din", cp_din, 64'hB1B0AFAEADACABAA);
    repeat (50) cyc();
    chk("to_not_early", 64'(err_timeout), 0);
    cyc();
    chk("to_err", 64'(err_timeout), 1);
    chk("to_frame", tx_frame, 64'hEEEEEEEEEEEEEEEE);
    cyc();
    chk("to_send", 64'(tx_send), 1);
    repeat (3) cyc();

    // result on the timeout cycle wins
    do_reset();
    frame_in(8'h40);
    cyc();
    echo_at(50, 64'hCAFEF00D12345678);
    chk("race_err", 64'(err_timeout), 0);
    chk("race_frame", tx_frame, 64'hCAFEF00D12345678);
    cyc();
    chk("race_send", 64'(tx_send), 1);
    repeat (3) cyc();

    // backpressure in SEND with dropped bytes, then overrun saturation
    do_reset();
    tx_busy = 1'b1;
    frame_in(8'h50);
    cyc();
    echo_at(10, 64'h0102030405060708);
    s0 = send_cnt;
    rx_byte = 8'h99; rx_byte_valid = 1'b1;
    repeat (5) cyc();
    rx_byte_valid = 1'b0;
    repeat (5) cyc();
    chk("bp_hold", 64'(send_cnt - s0), 0);
    chk("bp_state", 64'(state), 3);
    chk("bp_ovr5", 64'(overrun_count), 5);
    tx_busy = 1'b0;
    cyc();
    chk("bp_send", 64'(tx_send), 1);
    tx_busy = 1'b1;
    rx_byte_valid = 1'b1;
    repeat (300) cyc();
    rx_byte_valid = 1'b0;
    cyc();
    chk("ovr_sat", 64'(overrun_count), 255);
    chk("ovr_wait_tx", 64'(state), 4);
    tx_busy = 1'b0;
    repeat (3) cyc();

    // reset while waiting for the result
    frame_in(8'h60);
    cyc();
    repeat (5) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cp_dout = 64'hDEADBEEFDEADBEEF; cp_dout_valid = 1'b1;
    cyc();
    cp_dout_valid = 1'b0;
    s0 = send_cnt;
    repeat (10) cyc();
    chk("rst_mid_nosend", 64'(send_cnt - s0), 0);
    chk("rst_mid_state", 64'(state), 0);
    chk("rst_mid_data", cp_din | tx_frame, 0);
    chk("rst_mid_ovr", 64'(overrun_count), 0);
    frame_in(8'h21);
    cyc();
    chk("rst_mid_cp_din", cp_din, 64'h2827262524232221);
    s0 = send_cnt;
    echo_at(10, 64'h0F0E0D0C0B0A0908);
    cyc();
    chk("rst_mid_send", 64'(tx_send), 1);

    // TX busy rising two cycles after tx_send
    repeat (2) cyc();
    tx_busy = 1'b1;
    repeat (6) cyc();
    chk("late_hold", 64'(state), 4);
    tx_busy = 1'b0;
    repeat (2) cyc();
    chk("late_back", 64'(state), 0);
    chk("late_one_send", 64'(send_cnt - s0), 1);

    // randomized traffic
    do_reset();
    resp_at = -1; quiet = 0;
    repeat (4000) begin
      reset = ($urandom_range(0, 999) == 0);
      if (quiet > 0) begin
        rx_byte_valid = 1'b0; quiet--;
      end else begin
        rx_byte_valid = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 199) == 0) quiet = $urandom_range(90, 130);
      end
      rx_byte = 8'($urandom);
      if ($urandom_range(0, 5) == 0) tx_busy = ~tx_busy;
      cp_dout = {$urandom, $urandom};
      cp_dout_valid = (cnt == resp_at) || ($urandom_range(0, 299) == 0);
      cyc();
      if (m_cpv) resp_at = cnt + $urandom_range(1, 60);
    end
    reset = 1'b0; rx_byte_valid = 1'b0; cp_dout_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
